// File: rtl/sram_cmd_seq.sv
// Host-side command sequencer for sram_top: serialises write words onto the
// shift/load/w_en pins and turns reads into an r_en wait with timeout and a response.
module sram_cmd_seq #(
  parameter int ROWS       = 16,
  parameter int COLS       = 8,
  parameter int RD_TIMEOUT = 15,
  localparam int AW        = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [COLS-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            serial_in,
  output logic            shift,
  output logic            load,
  output logic            w_en,
  output logic            r_en,
  output logic [AW-1:0]   addr,
  input  logic            data_valid,
  input  logic [COLS-1:0] data_out
);

  localparam int CW = $clog2(COLS + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]      state, state_nx;
  logic [CW-1:0]   bcnt, bcnt_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [COLS-1:0] sreg, sreg_nx;
  logic [AW-1:0]   addr_nx;
  logic [COLS-1:0] rdata_nx;
  logic            err_nx;

  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    tcnt_nx  = tcnt;
    sreg_nx  = sreg;
    addr_nx  = addr;
    rdata_nx = rsp_rdata;
    err_nx   = rsp_err;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_nx  = cmd_addr;
          sreg_nx  = cmd_wdata;
          bcnt_nx  = '0;
          tcnt_nx  = '0;
          state_nx = cmd_we ? S_SHIFT : S_READ;
        end
      end
      S_SHIFT: begin
        sreg_nx = sreg << 1;
        bcnt_nx = bcnt + 1'b1;
        if (bcnt == CW'(COLS - 1)) state_nx = S_LOAD;
      end
      S_LOAD:  state_nx = S_WRITE;
      S_WRITE: state_nx = S_IDLE;
      S_READ: begin
        tcnt_nx = tcnt + 1'b1;
        // A data_valid on the final timeout cycle still counts as success.
        if (data_valid) begin
          rdata_nx = data_out;
          err_nx   = 1'b0;
          state_nx = S_RESP;
        end else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so each strobe is
  // aligned with the state it belongs to and only one can ever be set.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      bcnt      <= '0;
      tcnt      <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      serial_in <= 1'b0;
      shift     <= 1'b0;
      load      <= 1'b0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
      addr      <= '0;
    end else begin
      state     <= state_nx;
      bcnt      <= bcnt_nx;
      tcnt      <= tcnt_nx;
      cmd_ready <= (state_nx == S_IDLE);
      rsp_valid <= (state_nx == S_RESP);
      rsp_rdata <= rdata_nx;
      rsp_err   <= err_nx;
      serial_in <= (state_nx == S_SHIFT) && sreg_nx[COLS-1];
      shift     <= (state_nx == S_SHIFT);
      load      <= (state_nx == S_LOAD);
      w_en      <= (state_nx == S_WRITE);
      r_en      <= (state_nx == S_READ);
      addr      <= addr_nx;
    end
  end

  // Shift register holds only payload, so it carries no reset.
  always_ff @(posedge clk) begin
    sreg <= sreg_nx;
  end

endmodule

// File: tb/tb_sram_cmd_seq.sv
// Randomised bench for sram_cmd_seq: a pin-level SRAM model fed by the serial
// pins plus a word-level expected memory built from the issued commands.
module tb_sram_cmd_seq;
  localparam int ROWS       = 16;
  localparam int COLS       = 8;
  localparam int RD_TIMEOUT = 15;

  logic       clk, arst_n;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       serial_in, shift, load, w_en, r_en;
  logic [3:0] addr;
  logic       data_valid;
  logic [7:0] data_out;

  int n_chk = 0;
  int n_err = 0;

  bit [7:0] exp_mem  [ROWS];
  bit [7:0] sram_mem [ROWS];
  bit [7:0] sipo, latch;

  sram_cmd_seq #(.ROWS(ROWS), .COLS(COLS), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .serial_in(serial_in), .shift(shift), .load(load), .w_en(w_en), .r_en(r_en),
    .addr(addr), .data_valid(data_valid), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pin-level SRAM model: deserialise on shift, latch on load, commit on w_en.
  always @(negedge clk) begin
    if (arst_n) begin
      check("excl", 32'($countones({shift, load, w_en, r_en}) <= 1), 32'd1);
      check("sin_idle", 32'(!shift && serial_in), 32'd0);
      if (shift) sipo = {sipo[6:0], serial_in};
      if (load)  latch = sipo;
      if (w_en)  sram_mem[addr] = latch;
    end
  end

  task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("rdy_wait", 32'(n < 50), 32'd1);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic write_body(input logic [3:0] a, input logic [7:0] d,
                            input bit inject, input logic [3:0] na, input logic [7:0] nd);
    for (int i = 0; i < COLS; i++) begin
      check("shift", 32'(shift), 32'd1);
      check("sin", 32'(serial_in), 32'(d[COLS-1-i]));
      check("rdy_busy", 32'(cmd_ready), 32'd0);
      if (inject && i == 2) begin
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = na; cmd_wdata = nd;
      end
      data_valid = 1'($urandom_range(0, 1));
      data_out   = 8'($urandom);
      step();
    end
    data_valid = 1'b0;
    check("load", 32'(load), 32'd1);
    check("ld_shift", 32'(shift), 32'd0);
    check("rdy_busy", 32'(cmd_ready), 32'd0);
    step();
    check("w_en", 32'(w_en), 32'd1);
    check("w_addr", 32'(addr), 32'(a));
    check("rdy_busy", 32'(cmd_ready), 32'd0);
    step();
    check("w_en_off", 32'(w_en), 32'd0);
    check("rdy_idle", 32'(cmd_ready), 32'd1);
    exp_mem[a] = d;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    issue(1'b1, a, d);
    write_body(a, d, 1'b0, 4'd0, 8'd0);
  endtask

  // delay: READ cycle (1-based) on which data_valid is offered; beyond the
  // timeout window it is never offered and an error response is expected.
  task automatic do_read(input logic [3:0] a, input int delay, input int hold);
    bit hit;
    int lim;
    logic [7:0] exp_d;
    logic exp_e;
    hit   = (delay >= 1 && delay <= RD_TIMEOUT);
    lim   = hit ? delay : RD_TIMEOUT;
    exp_d = hit ? exp_mem[a] : 8'd0;
    exp_e = !hit;
    issue(1'b0, a, 8'($urandom));
    for (int c = 1; c <= lim; c++) begin
      check("r_en", 32'(r_en), 32'd1);
      check("r_addr", 32'(addr), 32'(a));
      check("rdy_rd", 32'(cmd_ready), 32'd0);
      check("rsp_early", 32'(rsp_valid), 32'd0);
      if (c == delay) begin
        data_valid = 1'b1; data_out = sram_mem[a];
      end else begin
        data_valid = 1'b0; data_out = 8'($urandom);
      end
      step();
    end
    data_valid = 1'b0;
    check("r_en_off", 32'(r_en), 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
    check("rsp_err", 32'(rsp_err), 32'(exp_e));
    for (int h = 0; h < hold; h++) begin
      rsp_ready  = 1'b0;
      data_valid = 1'($urandom_range(0, 1));
      data_out   = 8'($urandom);
      step();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", 32'(rsp_rdata), 32'(exp_d));
      check("bp_err", 32'(rsp_err), 32'(exp_e));
      check("bp_addr", 32'(addr), 32'(a));
      check("bp_rdy", 32'(cmd_ready), 32'd0);
    end
    data_valid = 1'b0;
    rsp_ready  = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
    check("rdy_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; data_valid = 1'b0; data_out = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(cmd_ready), 32'd0);
    check("rst_outs", 32'({rsp_valid, rsp_err, serial_in, shift, load, w_en, r_en}), 32'd0);
    check("rst_data", 32'({rsp_rdata, addr}), 32'd0);
    arst_n = 1'b1;
    step();
    check("rdy_first", 32'(cmd_ready), 32'd1);

    // Directed: the documented write / read / timeout / backpressure sequences.
    do_write(4'd3, 8'hA5);
    do_read(4'd3, 3, 0);
    do_read(4'd3, 0, 5);
    do_read(4'd3, RD_TIMEOUT, 1);

    // Second command held during SHIFT runs only after the first w_en.
    issue(1'b1, 4'd5, 8'h5A);
    write_body(4'd5, 8'h5A, 1'b1, 4'd9, 8'hC3);
    step();
    cmd_valid = 1'b0;
    write_body(4'd9, 8'hC3, 1'b0, 4'd0, 8'd0);
    do_read(4'd5, 2, 0);
    do_read(4'd9, 1, 0);

    // Reset pulse partway through a write abandons it.
    issue(1'b1, 4'd7, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      check("pre_rst_shift", 32'(shift), 32'd1);
      check("pre_rst_sin", 32'(serial_in), 32'd1);
      step();
    end
    arst_n = 1'b0;
    #1;
    check("arst_outs", 32'({cmd_ready, rsp_valid, rsp_err, serial_in, shift, load, w_en, r_en}), 32'd0);
    check("arst_data", 32'({rsp_rdata, addr}), 32'd0);
    step();
    check("arst_hold", 32'({w_en, load, cmd_ready}), 32'd0);
    arst_n = 1'b1;
    step();
    check("rel_rdy", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("no_w_en", 32'({w_en, load, shift}), 32'd0);
      step();
    end
    do_read(4'd7, 1, 0);
    do_write(4'd7, 8'h3C);
    do_read(4'd7, 2, 1);

    // Randomised traffic against the expected memory.
    for (int t = 0; t < 40; t++) begin
      logic       we;
      logic [3:0] a;
      logic [7:0] d;
      we = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, ROWS - 1));
      d  = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
      if (we) do_write(a, d);
      else    do_read(a, int'($urandom_range(1, 20)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
